// File: rtl/commit_monitor_pkg.sv
// Shared types and constants for the retirement monitor and its shadow register file.
package commit_monitor_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam int REG_NUM    = 32;

    localparam logic [DATA_W-1:0] CNT_SAT = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_RUN     = 2'd1,
        ST_DONE    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

endpackage

// File: rtl/commit_monitor_shadow_reg_file.sv
// Architectural shadow of the CPU register file: one write port, one combinational read port.
module shadow_reg_file
    import commit_monitor_pkg::*;
(
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  we_i,
    input  logic [REG_ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0]     wdata_i,
    input  logic [REG_ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0]     rdata_o
);

    logic [DATA_W-1:0] r_regs [REG_NUM];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < REG_NUM; i++) begin
                r_regs[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            r_regs[waddr_i] <= wdata_i;
        end
    end

    // No write bypass: a same-cycle read sees the value stored before this edge.
    assign rdata_o = r_regs[raddr_i];

endmodule

// File: rtl/commit_monitor.sv
// Retirement monitor: counts commits/stores, shadows the register file and flags done/timeout.
module commit_monitor
    import commit_monitor_pkg::*;
#(
    parameter int IDLE_LIMIT = 16,
    parameter int MAX_CYCLES = 1000
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  wb_regwrite_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic [DATA_W-1:0]     wb_data_i,
    input  logic                  mem_write_i,
    input  logic [DATA_W-1:0]     mem_addr_i,
    input  logic [DATA_W-1:0]     mem_wdata_i,
    input  logic [REG_ADDR_W-1:0] shadow_raddr_i,
    output logic [DATA_W-1:0]     shadow_rdata_o,
    output logic [DATA_W-1:0]     cycle_cnt_o,
    output logic [DATA_W-1:0]     commit_cnt_o,
    output logic [DATA_W-1:0]     store_cnt_o,
    output logic [DATA_W-1:0]     last_store_addr_o,
    output logic                  done_o,
    output logic                  timeout_o
);

    localparam int STREAK_W = $clog2(IDLE_LIMIT + 1);

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (v == CNT_SAT) ? v : v + 1'b1;
    endfunction

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DATA_W-1:0]   r_cycle_cnt;
    logic [DATA_W-1:0]   r_commit_cnt;
    logic [DATA_W-1:0]   r_store_cnt;
    logic [DATA_W-1:0]   r_last_store_addr;
    logic [STREAK_W-1:0] r_idle_streak;

    logic                w_commit;
    logic                w_store;
    logic                w_event;
    logic                w_count_en;
    logic                w_done;
    logic                w_timeout;
    logic [DATA_W-1:0]   w_cycle_nxt;
    logic [STREAK_W-1:0] w_streak_nxt;
    logic                w_hit_budget;
    logic                w_hit_idle;
    logic                w_unused;

    assign w_commit = wb_regwrite_i && (wb_rd_i != '0);
    assign w_store  = mem_write_i;
    assign w_event  = w_commit || w_store;
    // Store data is not tracked; only the address is of interest downstream.
    assign w_unused = ^mem_wdata_i;

    // Counters sit at 0 in WAIT, so the first event naturally yields cycle 1 / streak 0.
    assign w_cycle_nxt  = sat_inc(r_cycle_cnt);
    assign w_streak_nxt = w_event ? '0 : r_idle_streak + 1'b1;
    assign w_hit_budget = (w_cycle_nxt == DATA_W'(MAX_CYCLES));
    assign w_hit_idle   = (w_streak_nxt == STREAK_W'(IDLE_LIMIT));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_WAIT: begin
                if (w_event) begin
                    w_state_nxt = w_hit_budget ? ST_TIMEOUT : ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_hit_budget) begin
                    w_state_nxt = ST_TIMEOUT;
                end else if (w_hit_idle) begin
                    w_state_nxt = ST_DONE;
                end
            end
            default: begin
                w_state_nxt = r_state;
            end
        endcase
    end

    always_comb begin
        w_count_en = 1'b0;
        w_done     = 1'b0;
        w_timeout  = 1'b0;
        case (r_state)
            ST_WAIT:    w_count_en = w_event;
            ST_RUN:     w_count_en = 1'b1;
            ST_DONE:    w_done     = 1'b1;
            ST_TIMEOUT: w_timeout  = 1'b1;
            default:    w_count_en = 1'b0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cycle_cnt       <= '0;
            r_commit_cnt      <= '0;
            r_store_cnt       <= '0;
            r_last_store_addr <= '0;
            r_idle_streak     <= '0;
        end else if (w_count_en) begin
            r_cycle_cnt   <= w_cycle_nxt;
            r_idle_streak <= w_streak_nxt;
            if (w_commit) begin
                r_commit_cnt <= sat_inc(r_commit_cnt);
            end
            if (w_store) begin
                r_store_cnt       <= sat_inc(r_store_cnt);
                r_last_store_addr <= mem_addr_i;
            end
        end
    end

    shadow_reg_file u_shadow (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (w_count_en && w_commit),
        .waddr_i (wb_rd_i),
        .wdata_i (wb_data_i),
        .raddr_i (shadow_raddr_i),
        .rdata_o (shadow_rdata_o)
    );

    assign cycle_cnt_o       = r_cycle_cnt;
    assign commit_cnt_o      = r_commit_cnt;
    assign store_cnt_o       = r_store_cnt;
    assign last_store_addr_o = r_last_store_addr;
    assign done_o            = w_done;
    assign timeout_o         = w_timeout;

endmodule

// File: tb/tb_commit_monitor.sv
// Bench for commit_monitor: two instances (long and short cycle budget) against a behavioural model.
module tb_commit_monitor;

    localparam int IDLE = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_regwrite;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [4:0]  raddr;

    logic [31:0] rdata [2];
    logic [31:0] cyc   [2];
    logic [31:0] com   [2];
    logic [31:0] sto   [2];
    logic [31:0] laddr [2];
    logic        done  [2];
    logic        tmo   [2];

    always #5 clk = ~clk;

    commit_monitor #(.IDLE_LIMIT(IDLE), .MAX_CYCLES(1000)) dut0 (
        .clk_i(clk), .rst_i(rst), .wb_regwrite_i(wb_regwrite), .wb_rd_i(wb_rd),
        .wb_data_i(wb_data), .mem_write_i(mem_write), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .shadow_raddr_i(raddr), .shadow_rdata_o(rdata[0]),
        .cycle_cnt_o(cyc[0]), .commit_cnt_o(com[0]), .store_cnt_o(sto[0]),
        .last_store_addr_o(laddr[0]), .done_o(done[0]), .timeout_o(tmo[0])
    );

    commit_monitor #(.IDLE_LIMIT(IDLE), .MAX_CYCLES(20)) dut1 (
        .clk_i(clk), .rst_i(rst), .wb_regwrite_i(wb_regwrite), .wb_rd_i(wb_rd),
        .wb_data_i(wb_data), .mem_write_i(mem_write), .mem_addr_i(mem_addr),
        .mem_wdata_i(mem_wdata), .shadow_raddr_i(raddr), .shadow_rdata_o(rdata[1]),
        .cycle_cnt_o(cyc[1]), .commit_cnt_o(com[1]), .store_cnt_o(sto[1]),
        .last_store_addr_o(laddr[1]), .done_o(done[1]), .timeout_o(tmo[1])
    );

    // Reference model: one record per instance, updated once per rising edge.
    int unsigned m_max  [2];
    bit          m_run  [2];
    bit          m_done [2];
    bit          m_tmo  [2];
    logic [31:0] m_cyc  [2];
    logic [31:0] m_com  [2];
    logic [31:0] m_sto  [2];
    logic [31:0] m_addr [2];
    int          m_idle [2];
    logic [31:0] m_reg  [2][32];

    int n_checks = 0;
    int n_fail   = 0;

    function automatic logic [31:0] sat1(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k] = 0; m_done[k] = 0; m_tmo[k] = 0;
            m_cyc[k] = 0; m_com[k] = 0; m_sto[k] = 0; m_addr[k] = 0; m_idle[k] = 0;
            for (int r = 0; r < 32; r++) m_reg[k][r] = 0;
        end
    endtask

    task automatic model_clock();
        bit c;
        bit s;
        c = wb_regwrite && (wb_rd != 5'd0);
        s = mem_write;
        for (int k = 0; k < 2; k++) begin
            if (!m_done[k] && !m_tmo[k] && (m_run[k] || c || s)) begin
                m_run[k] = 1;
                m_cyc[k] = sat1(m_cyc[k]);
                if (c) begin
                    m_reg[k][wb_rd] = wb_data;
                    m_com[k] = sat1(m_com[k]);
                end
                if (s) begin
                    m_sto[k]  = sat1(m_sto[k]);
                    m_addr[k] = mem_addr;
                end
                m_idle[k] = (c || s) ? 0 : m_idle[k] + 1;
                if (m_cyc[k] == m_max[k]) m_tmo[k] = 1;
                else if (m_idle[k] == IDLE) m_done[k] = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic put(input bit we, input logic [4:0] rd, input logic [31:0] d,
                       input bit mw, input logic [31:0] a);
        wb_regwrite = we; wb_rd = rd; wb_data = d;
        mem_write = mw; mem_addr = a; mem_wdata = $urandom;
    endtask

    task automatic apply_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #2;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        put(0, 0, 0, 0, 0);
        raddr = 5'd5;
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({cyc[k], com[k], sto[k], laddr[k], done[k], tmo[k], rdata[k]} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs[%0d]: got cyc=%0h com=%0h sto=%0h addr=%0h done=%b to=%b rd=%0h, expected all 0",
                         k, cyc[k], com[k], sto[k], laddr[k], done[k], tmo[k], rdata[k]);
            end
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (cyc[0] !== 32'd0) begin
            n_fail++;
            $display("FAIL wait_idle_cycle_cnt: got %0d expected 0", cyc[0]);
        end
    endtask

    task automatic test_commit_basic();
        apply_reset();
        put(1, 5'd1, 32'd10, 0, 0); tick();
        put(1, 5'd2, 32'd3, 0, 0);  tick();
        put(1, 5'd0, 32'd7, 0, 0);  tick();
        put(0, 0, 0, 0, 0);
        n_checks++;
        if (com[0] !== 32'd2) begin
            n_fail++;
            $display("FAIL basic_commit_cnt: got %0d expected 2", com[0]);
        end
        n_checks++;
        if (cyc[0] !== m_cyc[0]) begin
            n_fail++;
            $display("FAIL basic_cycle_cnt: got %0d expected %0d", cyc[0], m_cyc[0]);
        end
        raddr = 5'd1; #1;
        n_checks++;
        if (rdata[0] !== 32'd10) begin
            n_fail++;
            $display("FAIL basic_shadow1: got %0d expected 10", rdata[0]);
        end
        raddr = 5'd2; #1;
        n_checks++;
        if (rdata[0] !== 32'd3) begin
            n_fail++;
            $display("FAIL basic_shadow2: got %0d expected 3", rdata[0]);
        end
        raddr = 5'd0; #1;
        n_checks++;
        if (rdata[0] !== 32'd0) begin
            n_fail++;
            $display("FAIL basic_shadow0: got %0d expected 0", rdata[0]);
        end
    endtask

    task automatic test_shadow_rw();
        apply_reset();
        put(1, 5'd4, 32'd9, 0, 0);
        raddr = 5'd4;
        #1;
        n_checks++;
        if (rdata[0] !== 32'd0) begin
            n_fail++;
            $display("FAIL shadow_same_cycle: got %0d expected 0", rdata[0]);
        end
        tick();
        put(0, 0, 0, 0, 0);
        n_checks++;
        if (rdata[0] !== 32'd9) begin
            n_fail++;
            $display("FAIL shadow_next_cycle: got %0d expected 9", rdata[0]);
        end
    endtask

    task automatic test_same_cycle();
        apply_reset();
        put(1, 5'd3, 32'd5, 1, 32'd8);
        tick();
        put(0, 0, 0, 0, 0);
        raddr = 5'd3;
        #1;
        n_checks++;
        if ({com[0], sto[0], laddr[0], rdata[0]} !== {32'd1, 32'd1, 32'd8, 32'd5}) begin
            n_fail++;
            $display("FAIL same_cycle: got com=%0d sto=%0d addr=%0d r3=%0d expected 1 1 8 5",
                     com[0], sto[0], laddr[0], rdata[0]);
        end
    endtask

    task automatic test_done();
        logic [31:0] com_hold;
        logic [31:0] cyc_hold;
        logic [31:0] r6_hold;
        apply_reset();
        put(1, 5'd6, $urandom, 0, 0);
        tick();
        for (int i = 0; i < 10; i++) begin
            if ($urandom_range(0, 99) < 40) put(0, 0, 0, 0, 0);
            else put($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom,
                     $urandom_range(0, 1), $urandom);
            tick();
        end
        put(0, 0, 0, 1, 32'h40);
        tick();
        put(0, 0, 0, 0, 0);
        for (int i = 1; i <= 20; i++) begin
            tick();
            n_checks++;
            if (done[0] !== (i >= IDLE) || done[0] !== m_done[0]) begin
                n_fail++;
                $display("FAIL done_timing idle=%0d: got %b expected %b", i, done[0], (i >= IDLE));
            end
        end
        com_hold = com[0];
        cyc_hold = cyc[0];
        raddr = 5'd6; #1;
        r6_hold = rdata[0];
        for (int i = 0; i < 3; i++) begin
            put(1, 5'd6, 32'hDEAD_0000 + 32'(i), 1, 32'h100);
            tick();
        end
        put(0, 0, 0, 0, 0);
        n_checks++;
        if ({com[0], cyc[0], rdata[0], done[0]} !== {com_hold, cyc_hold, r6_hold, 1'b1}) begin
            n_fail++;
            $display("FAIL done_frozen: got com=%0d cyc=%0d r6=%0h done=%b expected %0d %0d %0h 1",
                     com[0], cyc[0], rdata[0], done[0], com_hold, cyc_hold, r6_hold);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        for (int i = 1; i <= 25; i++) begin
            if ($urandom_range(0, 1) == 1) put(1, 5'($urandom_range(1, 31)), $urandom, 0, 0);
            else put($urandom_range(0, 1), 5'($urandom_range(0, 31)), $urandom, 1, $urandom);
            tick();
            n_checks++;
            if (tmo[1] !== (i >= 20) || done[1] !== 1'b0) begin
                n_fail++;
                $display("FAIL timeout_timing cyc=%0d: got to=%b done=%b expected to=%b done=0",
                         i, tmo[1], done[1], (i >= 20));
            end
        end
        put(0, 0, 0, 0, 0);
        n_checks++;
        if ({cyc[1], com[1], sto[1]} !== {32'd20, m_com[1], m_sto[1]}) begin
            n_fail++;
            $display("FAIL timeout_frozen: got cyc=%0d com=%0d sto=%0d expected 20 %0d %0d",
                     cyc[1], com[1], sto[1], m_com[1], m_sto[1]);
        end
    endtask

    task automatic test_reset_mid_run();
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            put(1, 5'(i + 1), 32'(100 + i), 0, 0);
            tick();
        end
        put(0, 0, 0, 1, 32'h77);
        n_checks++;
        if (com[0] !== 32'd5) begin
            n_fail++;
            $display("FAIL midrun_pre_commit_cnt: got %0d expected 5", com[0]);
        end
        raddr = 5'd3;
        apply_reset();
        put(0, 0, 0, 0, 0);
        n_checks++;
        if ({cyc[0], com[0], sto[0], laddr[0], done[0], tmo[0], rdata[0]} !== '0) begin
            n_fail++;
            $display("FAIL midrun_reset: got cyc=%0d com=%0d sto=%0d addr=%0h r3=%0h expected all 0",
                     cyc[0], com[0], sto[0], laddr[0], rdata[0]);
        end
        for (int i = 0; i < 3; i++) tick();
        n_checks++;
        if (cyc[0] !== 32'd0) begin
            n_fail++;
            $display("FAIL midrun_wait_cycle_cnt: got %0d expected 0", cyc[0]);
        end
        put(1, 5'd9, 32'd1, 0, 0);
        tick();
        put(0, 0, 0, 0, 0);
        n_checks++;
        if ({com[0], cyc[0]} !== {32'd1, 32'd1}) begin
            n_fail++;
            $display("FAIL midrun_restart: got com=%0d cyc=%0d expected 1 1", com[0], cyc[0]);
        end
    endtask

    task automatic test_random();
        int gap;
        for (int ep = 0; ep < 4; ep++) begin
            apply_reset();
            gap = 0;
            for (int n = 0; n < 80; n++) begin
                if (gap > 0) begin
                    put(0, 0, 0, 0, 0);
                    gap--;
                end else if ($urandom_range(0, 99) < 12) begin
                    put(0, 0, 0, 0, 0);
                    gap = $urandom_range(4, 20);
                end else begin
                    put($urandom_range(0, 99) < 70,
                        ($urandom_range(0, 9) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
                        $urandom, $urandom_range(0, 99) < 30, $urandom);
                end
                raddr = 5'($urandom_range(0, 31));
                tick();
                for (int k = 0; k < 2; k++) begin
                    n_checks++;
                    if (cyc[k] !== m_cyc[k]) begin
                        n_fail++;
                        $display("FAIL rnd_cycle_cnt[%0d]: got %0d expected %0d", k, cyc[k], m_cyc[k]);
                    end
                    n_checks++;
                    if (com[k] !== m_com[k]) begin
                        n_fail++;
                        $display("FAIL rnd_commit_cnt[%0d]: got %0d expected %0d", k, com[k], m_com[k]);
                    end
                    n_checks++;
                    if (sto[k] !== m_sto[k] || laddr[k] !== m_addr[k]) begin
                        n_fail++;
                        $display("FAIL rnd_store[%0d]: got cnt=%0d addr=%0h expected %0d %0h",
                                 k, sto[k], laddr[k], m_sto[k], m_addr[k]);
                    end
                    n_checks++;
                    if (done[k] !== m_done[k] || tmo[k] !== m_tmo[k]) begin
                        n_fail++;
                        $display("FAIL rnd_flags[%0d]: got done=%b to=%b expected %b %b",
                                 k, done[k], tmo[k], m_done[k], m_tmo[k]);
                    end
                    n_checks++;
                    if (rdata[k] !== m_reg[k][raddr]) begin
                        n_fail++;
                        $display("FAIL rnd_shadow[%0d] r%0d: got %0h expected %0h",
                                 k, raddr, rdata[k], m_reg[k][raddr]);
                    end
                end
            end
        end
    endtask

    initial begin
        m_max[0] = 1000;
        m_max[1] = 20;
        model_reset();
        test_reset();
        test_commit_basic();
        test_shadow_rw();
        test_same_cycle();
        test_done();
        test_timeout();
        test_reset_mid_run();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/commit_monitor.md
# commit_monitor

Synthesizable retirement monitor for the pipelined CPU, sitting directly downstream of the MEM/WB pipeline register and the data-memory write port. It consumes each cycle's write-back and store events and maintains a shadow register file and retirement counters. It raises a done or timeout flag so a bench or on-chip harness can stop the run deterministically, instead of relying on a fixed cycle budget.

## Interface
Parameters:
- IDLE_LIMIT, 16: consecutive cycles without a commit or store that declare the program finished.
- MAX_CYCLES, 1000: cycle budget; reaching it before done raises timeout.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- wb_regwrite_i  in  1  MEM/WB RegWrite for the instruction retiring this cycle.
- wb_rd_i  in  5  destination register of the retiring instruction.
- wb_data_i  in  32  write-back data (after the MemToReg mux).
- mem_write_i  in  1  store issued to data memory this cycle.
- mem_addr_i  in  32  store byte address.
- mem_wdata_i  in  32  store data.
- shadow_raddr_i  in  5  shadow register file read address.
- shadow_rdata_o  out  32  shadow register contents, combinational read of stored state, no write bypass.
- cycle_cnt_o  out  32  cycles spent in RUN.
- commit_cnt_o  out  32  register write-backs committed.
- store_cnt_o  out  32  stores observed.
- last_store_addr_o  out  32  address of the most recent store.
- done_o  out  1  program finished (sticky).
- timeout_o  out  1  budget exhausted (sticky).

## Operation
- States: WAIT, RUN, DONE, TIMEOUT.
- WAIT: entered on reset. All counters are held at 0. Go to RUN on the first cycle where an event is present.
- Event: a commit (wb_regwrite_i=1 and wb_rd_i≠0) or a store (mem_write_i=1).
- The first event is counted in the same cycle it causes the WAIT→RUN transition.
- RUN:
  - cycle_cnt increments every cycle.
  - Each commit writes shadow[wb_rd_i] with wb_data_i and increments commit_cnt.
  - Each store increments store_cnt and captures last_store_addr.
  - The idle streak counter resets to 0 on any event; otherwise it increments.
- RUN→DONE when the idle streak reaches IDLE_LIMIT.
- RUN→TIMEOUT when cycle_cnt reaches MAX_CYCLES.
  - If both conditions hold in the same cycle, TIMEOUT wins.
- DONE and TIMEOUT are absorbing until reset. In these states, counters and the shadow file freeze and incoming events are ignored.
- A write to r0 is never committed or counted; shadow[0] stays 0.
- A commit and a store in the same cycle are both counted.
- Counters saturate at 32'hFFFFFFFF; they never wrap.
- Idle streak width is clog2(IDLE_LIMIT+1) bits.

## Timing
- Reset (asynchronous, immediate):
  - State goes to WAIT.
  - All counters, last_store_addr_o, done_o and timeout_o go to 0.
  - All 32 shadow registers go to 0.
- Counter and flag outputs are registered, visible the cycle after the causing edge.
- Shadow write takes effect at the clock edge. A read of the same address in the same cycle returns the old value.
- done_o asserts exactly IDLE_LIMIT cycles after the last event's edge.
- Reset asserted mid-RUN discards everything, with no partial state retained. The first post-reset event restarts counting from 0.

## Structure
- Package commit_monitor_pkg:
  - State enum (WAIT, RUN, DONE, TIMEOUT).
  - REG_ADDR_W=5, DATA_W=32, REG_NUM=32, counter saturation constant.
- Sub-module shadow_reg_file:
  - 32×32 flops with async reset.
  - One write port; r0 writes are suppressed.
  - One combinational read port.
- Top module holds the FSM, counters and idle-streak logic.

## Test plan
- Reset, then drive commit rd=1 data=10, rd=2 data=3, rd=0 data=7 → commit_cnt_o=2, shadow[1]=10, shadow[2]=3, shadow[0]=0.
- IDLE_LIMIT=16, last event at edge N → done_o rises after edge N+16. Later commits leave commit_cnt_o and the shadow file unchanged.
- MAX_CYCLES=20, an event every cycle → timeout_o=1 and done_o=0; cycle_cnt_o=20 frozen.
- Same-cycle commit rd=3 data=5 and store addr=8 → commit_cnt_o=1, store_cnt_o=1, last_store_addr_o=8.
- rst_i pulsed mid-RUN after 5 commits → all outputs 0 and state WAIT. The next commit gives commit_cnt_o=1.
- Read shadow[4] in the cycle it is written with 9 → old value 0; reading it the next cycle → 9.
